// File: rtl/music_player.sv
// music_player: steps a beat index through a tone lookup and plays each returned tone as a square wave.
module music_player #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BEAT_FREQ  = 8,
  parameter int unsigned BEAT_LEN   = 32,
  parameter int unsigned SILENCE_HZ = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        loop,
  input  logic [31:0] tone,
  output logic [7:0]  ibeat_num,
  output logic        audio_out,
  output logic        beat_tick,
  output logic        playing,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_e;
  localparam logic [31:0] TICKS_M1 = CLK_FREQ / BEAT_FREQ - 1;
  localparam logic [31:0] CLK_HZ   = CLK_FREQ;
  localparam logic [31:0] SIL_HZ   = SILENCE_HZ;
  localparam logic [7:0]  LAST     = 8'(BEAT_LEN - 1);
  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d, acc_q, acc_d, tone_q, sum;
  logic [7:0]  beat_q, beat_d;
  logic        audio_q, audio_d, tick_q, tick_d, done_q, done_d, playing_q, playing_d;
  logic        wrap, last, rest, step, run;
  // tone from the lookup is retimed so pitch follows the beat index one cycle later
  always_ff @(posedge clk) tone_q <= tone;
  // state, beat position and oscillator registers; active-low reset overrides everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      beat_q    <= '0;
      acc_q     <= '0;
      audio_q   <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      beat_q    <= beat_d;
      acc_q     <= acc_d;
      audio_q   <= audio_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      playing_q <= playing_d;
    end
  end
  // sequencing of play/pause/song end plus the phase-accumulator square-wave generator
  always_comb begin
    wrap    = timer_q == TICKS_M1;
    last    = beat_q == LAST;
    rest    = tone_q == '0 || tone_q >= SIL_HZ;
    sum     = acc_q + {tone_q[30:0], 1'b0};
    step    = sum >= CLK_HZ;
    state_d = state_q;
    timer_d = timer_q;
    beat_d  = beat_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (play) begin
        state_d = PLAY;
        timer_d = '0;
        beat_d  = '0;
      end
      PAUSE: state_d = play ? PLAY : PAUSE;
      PLAY: begin
        timer_d = wrap ? '0 : timer_q + 32'd1;
        tick_d  = wrap;
        done_d  = wrap && last;
        beat_d  = !wrap ? beat_q : last ? 8'd0 : beat_q + 8'd1;
        state_d = (wrap && last && !loop) ? IDLE : play ? PLAY : PAUSE;
      end
      default: state_d = IDLE;
    endcase
    run       = state_q == PLAY && state_d == PLAY && !rest;
    acc_d     = !run ? '0 : step ? sum - CLK_HZ : sum;
    audio_d   = run && (audio_q ^ step);
    playing_d = state_d == PLAY;
  end
  assign ibeat_num = beat_q;
  assign audio_out = audio_q;
  assign beat_tick = tick_q;
  assign done      = done_q;
  assign playing   = playing_q;
endmodule

// File: tb/tb_music_player.sv
// tb_music_player: directed checks of reset, tone synthesis, beat stepping, song end, pause and rests.
module tb_music_player;
  logic        clk = 1'b0, rst = 1'b0, play = 1'b0, loop = 1'b0, use_tab = 1'b0;
  logic [31:0] tone, tone_ovr = 32'd50;
  logic [31:0] tab [4];
  logic [7:0]  ibeat_num;
  logic        audio_out, beat_tick, playing, done;
  int          n_tests = 0, n_fail = 0, ticks = 0, dones = 0, aud = 0;
  music_player #(.CLK_FREQ(1000), .BEAT_FREQ(10), .BEAT_LEN(4), .SILENCE_HZ(20000)) dut (
    .clk(clk), .rst(rst), .play(play), .loop(loop), .tone(tone),
    .ibeat_num(ibeat_num), .audio_out(audio_out), .beat_tick(beat_tick),
    .playing(playing), .done(done)
  );
  always #5 clk = ~clk;
  assign tone = use_tab ? tab[ibeat_num[1:0]] : tone_ovr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    tab[0] = 32'd50; tab[1] = 32'd100; tab[2] = 32'd250; tab[3] = 32'd0;
    rst = 1'b0; play = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rst_tick", 32'(beat_tick), 0);
      chk("rst_done", 32'(done), 0);
    end
    chk("rst_beat", 32'(ibeat_num), 0);
    chk("rst_audio", 32'(audio_out), 0);
    chk("rst_playing", 32'(playing), 0);
    rst = 1'b1;
    step(1);
    chk("start_playing", 32'(playing), 1);
    chk("start_beat", 32'(ibeat_num), 0);
    step(9);  chk("t50_e9", 32'(audio_out), 0);
    step(1);  chk("t50_e10", 32'(audio_out), 1);
    step(9);  chk("t50_e19", 32'(audio_out), 1);
    step(1);  chk("t50_e20", 32'(audio_out), 0);
    step(5);  tone_ovr = 32'd250;
    step(1);  chk("t250_e26", 32'(audio_out), 0);
    step(1);  chk("t250_e27", 32'(audio_out), 1);
    step(1);  chk("t250_e28", 32'(audio_out), 1);
    step(1);  chk("t250_e29", 32'(audio_out), 0);
    step(2);  chk("t250_e31", 32'(audio_out), 1);
    rst = 1'b0;
    step(1);
    chk("rst2_playing", 32'(playing), 0);
    rst = 1'b1; use_tab = 1'b1;
    step(1);
    for (int k = 1; k <= 400; k++) begin
      step(1);
      ticks += int'(beat_tick);
      dones += int'(done);
      if (k % 100 == 0 || k % 100 == 99) begin
        chk("beat_idx", 32'(ibeat_num), 32'((k / 100) % 4));
        chk("beat_tick", 32'(beat_tick), 32'(k % 100 == 0));
      end
      if (k < 400 && k % 100 == 50) chk("beat_playing", 32'(playing), 1);
    end
    chk("end_done", 32'(done), 1);
    chk("end_playing", 32'(playing), 0);
    chk("end_ticks", 32'(ticks), 4);
    chk("end_dones", 32'(dones), 1);
    step(1);
    chk("restart_playing", 32'(playing), 1);
    chk("restart_done", 32'(done), 0);
    loop = 1'b1;
    step(399); chk("loop_pre_beat", 32'(ibeat_num), 3);
    step(1);
    chk("loop_done", 32'(done), 1);
    chk("loop_tick", 32'(beat_tick), 1);
    chk("loop_playing", 32'(playing), 1);
    chk("loop_beat", 32'(ibeat_num), 0);
    step(1);
    chk("loop_done_clr", 32'(done), 0);
    chk("loop_playing2", 32'(playing), 1);
    step(135);
    chk("pre_pause_beat", 32'(ibeat_num), 1);
    play = 1'b0;
    step(1);
    chk("pause_playing", 32'(playing), 0);
    chk("pause_audio", 32'(audio_out), 0);
    aud = 0;
    for (int i = 1; i < 50; i++) begin
      step(1);
      aud += int'(audio_out);
    end
    chk("pause_audio_hold", 32'(aud), 0);
    chk("pause_beat_hold", 32'(ibeat_num), 1);
    play = 1'b1;
    step(1);
    chk("resume_playing", 32'(playing), 1);
    step(62); chk("resume_beat_pre", 32'(ibeat_num), 1);
    step(1);
    chk("resume_beat", 32'(ibeat_num), 2);
    chk("resume_tick", 32'(beat_tick), 1);
    step(20);
    chk("mid2_beat", 32'(ibeat_num), 2);
    rst = 1'b0;
    step(1);
    chk("mid_rst_beat", 32'(ibeat_num), 0);
    chk("mid_rst_playing", 32'(playing), 0);
    chk("mid_rst_audio", 32'(audio_out), 0);
    chk("mid_rst_tick", 32'(beat_tick), 0);
    chk("mid_rst_done", 32'(done), 0);
    use_tab = 1'b0; tone_ovr = 32'd20000; loop = 1'b0; rst = 1'b1;
    step(1);
    aud = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      aud += int'(audio_out);
    end
    chk("rest_hi", 32'(aud), 0);
    tone_ovr = 32'd0;
    aud = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      aud += int'(audio_out);
    end
    chk("rest_zero", 32'(aud), 0);
    tone_ovr = 32'd50;
    step(10); chk("unrest_e10", 32'(audio_out), 0);
    step(1);  chk("unrest_e11", 32'(audio_out), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/music_player.md
Name: music_player

Overview:
- Consumer end of the beat-to-tone lookup interface.
- Drives the 8-bit beat index into the tone lookup module and advances it at a fixed quarter-beat rate.
- Takes the returned 32-bit tone frequency (Hz) and synthesises a 50%-duty square wave for the speaker/audio pin.
- Adds play/pause/loop sequencing and end-of-song signalling. Sits between the top-level controls and the speaker output.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz; must be < 2^31.
- BEAT_FREQ, 8: quarter-beat steps per second.
- BEAT_LEN, 32: number of quarter-beat entries in the song, 1..256.
- SILENCE_HZ, 20000: any tone >= this value, or tone == 0, is treated as a rest.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- play  in  1  level; 1 = run, 0 = pause/idle
- loop  in  1  level; 1 = wrap to beat 0 at song end
- tone  in  32  frequency in Hz returned by the lookup for ibeat_num
- ibeat_num  out  8  current quarter-beat index, driven to the lookup
- audio_out  out  1  square-wave speaker drive
- beat_tick  out  1  one-cycle pulse on every beat advance
- playing  out  1  high while in PLAY
- done  out  1  one-cycle pulse when the last beat completes

Behaviour:

Reset and state machine:
- Reset (rst == 0 at a clk edge) forces: state IDLE, ibeat_num 0, beat timer 0, phase accumulator 0, audio_out 0, beat_tick 0, playing 0, done 0.
- Reset wins over every other input in the same cycle, including mid-song.
- FSM states are IDLE, PLAY and PAUSE.
  - IDLE: play == 1 moves to PLAY next cycle, starting at beat 0 with the timer at 0.
  - PLAY: play == 0 moves to PAUSE.
  - PAUSE: play == 1 moves to PLAY and resumes from the held beat and timer value.
- In PAUSE and IDLE:
  - The beat timer and ibeat_num hold.
  - audio_out is 0 and the accumulator is cleared.

Beat timer:
- TICKS = CLK_FREQ/BEAT_FREQ, integer division.
- In PLAY the timer counts 0..TICKS-1.
- At TICKS-1:
  - The timer returns to 0.
  - beat_tick pulses on the following cycle.
  - ibeat_num advances on the same edge as the timer wrap.

Song end:
- When ibeat_num == BEAT_LEN-1 and the timer reaches TICKS-1, done pulses with beat_tick.
  - loop == 1: ibeat_num wraps to 0 and the FSM stays in PLAY.
  - loop == 0: ibeat_num returns to 0 and the FSM goes to IDLE.
- From IDLE, play still high restarts playback on the next cycle.
- loop is sampled only at the wrap edge.
- play falling on the same cycle as a beat advance: the advance completes, then the FSM enters PAUSE.

Tone path:
- tone is registered every cycle into tone_q, so there is a one-cycle latency from an ibeat_num change to the new pitch.
- tone_q is a rest if tone_q == 0 or tone_q >= SILENCE_HZ. On a rest, audio_out is 0 and the accumulator is cleared.
- Otherwise the block runs an NCO with a 32-bit accumulator. Each PLAY cycle:
  - acc_next = acc + 2*tone_q.
  - If acc_next >= CLK_FREQ: acc = acc_next - CLK_FREQ and audio_out toggles.
  - Else: acc = acc_next.
- The output frequency therefore equals tone_q Hz.
- Width rule: 2*tone_q < 2*SILENCE_HZ, so the sum never overflows 32 bits.
- Tone changes between non-rest values are phase-continuous: the accumulator and audio_out are not reset.
- Leaving a rest restarts from acc 0 with audio_out 0.

Outputs:
- All outputs are registered; none are combinational from inputs.

Test Plan:
Bench parameters: CLK_FREQ=1000, BEAT_FREQ=10 (TICKS=100), BEAT_LEN=4. The bench models the lookup as a table.

- Reset: hold rst=0 for 5 cycles with play=1 -> ibeat_num=0, audio_out=0, playing=0, no pulses. Assert rst=0 mid-beat 2 -> the same values on the next edge.
- Tone: play=1, tone=50 constant -> audio_out toggles every 10 cycles (20-cycle period); tone=250 -> toggles every 2 cycles; the switch occurs with no glitch and no phase reset.
- Beat advance: play=1 -> ibeat_num steps 0,1,2,3 at 100-cycle intervals; beat_tick is high exactly 1 cycle per step; playing=1 throughout.
- Song end: loop=0 -> after 400 cycles done=1 for one cycle, then ibeat_num=0 and playing=0 for one cycle before restarting. loop=1 -> wrap 3->0 with done pulse, playing stays 1.
- Pause: drop play at timer=37 in beat 1 for 50 cycles -> ibeat_num holds at 1, audio_out=0. On resume, beat 2 arrives exactly 63 PLAY cycles later.
- Rests: tone=20000 and tone=0 -> audio_out stays 0. Then tone=50 -> the first toggle occurs 10 cycles after tone_q updates.
